id_ex_stage_reg: RTL and testbench

Parametrised pipeline stage register that generalises the ID→EX latch to any payload width. It uses a valid/ready handshake, a stall input, a flush that inserts bubbles, and an optional two-entry skid buffer. It sits between any two pipeline stages (ID/EX, EX/MEM, MEM/WB). Control bits are forced to zero whenever no valid instruction is presented, so the downstream stages see a bubble and take no side effects.

---
 rtl/id_ex_stage_reg_if.sv | 28 ++
 rtl/id_ex_stage_reg.sv | 102 ++++++++++
 tb/tb_id_ex_stage_reg.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_reg_if.sv
// Handshake bundle for id_ex_stage_reg: upstream valid/ready, downstream valid/ready,
// hazard controls (stall, flush) and the occupancy status.
interface id_ex_stage_reg_if #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              stall;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;

  modport master (
    output in_valid, in_data, in_ctrl, stall, flush, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, occupancy
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, stall, flush, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, occupancy
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// Generic pipeline stage register with valid/ready, stall, flush-to-bubble.
// Define PIPE_SKID_EN for a two-entry skid buffer with a registered in_ready.
module id_ex_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16
) (
  input logic               clk_i,
  input logic               rst_ni,
  id_ex_stage_reg_if.slave  bus
);

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  entry_t main_q, main_d;
  entry_t in_e;
  logic   push, pop;

  assign in_e = '{vld: 1'b1, data: bus.in_data, ctrl: bus.in_ctrl};
  assign push = bus.in_valid & bus.in_ready & ~bus.flush;
  assign pop  = main_q.vld & bus.out_ready & ~bus.stall;

  // Head entry drives the outputs; control is masked so a bubble never carries side effects.
  assign bus.out_valid = main_q.vld;
  assign bus.out_data  = main_q.data;
  assign bus.out_ctrl  = main_q.ctrl & {CTRL_W{main_q.vld}};

`ifdef PIPE_SKID_EN
  entry_t skid_q, skid_d;
  logic   rdy_q, rdy_d;

  // The skid entry is only ever valid while the main entry is valid.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (bus.flush) begin
      main_d.vld  = 1'b0;
      main_d.ctrl = '0;
      skid_d.vld  = 1'b0;
      skid_d.ctrl = '0;
    end else if (skid_q.vld) begin
      if (pop) begin
        main_d     = skid_q;
        skid_d.vld = 1'b0;
      end
    end else if (main_q.vld) begin
      if (push && pop) begin
        main_d = in_e;
      end else if (pop) begin
        main_d.vld = 1'b0;
      end else if (push) begin
        skid_d = in_e;
      end
    end else if (push) begin
      main_d = in_e;
    end
    rdy_d = ~(main_d.vld & skid_d.vld);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      skid_q <= '0;
      rdy_q  <= 1'b1;
    end else begin
      skid_q <= skid_d;
      rdy_q  <= rdy_d;
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.occupancy = 2'(main_q.vld) + 2'(skid_q.vld);
`else
  // Accept when empty, or when the head leaves in this same cycle.
  assign bus.in_ready = ~main_q.vld | (bus.out_ready & ~bus.stall);

  always_comb begin
    main_d = main_q;
    if (bus.flush) begin
      main_d.vld  = 1'b0;
      main_d.ctrl = '0;
    end else if (push) begin
      main_d = in_e;
    end else if (pop) begin
      main_d.vld = 1'b0;
    end
  end

  assign bus.occupancy = {1'b0, main_q.vld};
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      main_q <= '0;
    end else begin
      main_q <= main_d;
    end
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed vector table, build-specific
// sequences, then randomized traffic against a queue-based reference model.
module tb_id_ex_stage_reg;

  localparam int DW = 64;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

  id_ex_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic          r, iv;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic          st, fl, ordy;
    logic          ck_rdy, e_rdy;
    logic          ev;
    logic [DW-1:0] ed;
    logic [CW-1:0] ec;
    logic [1:0]    eo;
    logic          ck_d;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  vec_t vecs[$];
  ent_t mq[$];

  function automatic vec_t v(input logic r, iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                             input logic st, fl, ordy, ck_rdy, e_rdy, ev,
                             input logic [DW-1:0] ed, input logic [CW-1:0] ec,
                             input logic [1:0] eo, input logic ck_d);
    vec_t x;
    x.r = r; x.iv = iv; x.d = d; x.c = c; x.st = st; x.fl = fl; x.ordy = ordy;
    x.ck_rdy = ck_rdy; x.e_rdy = e_rdy; x.ev = ev; x.ed = ed; x.ec = ec; x.eo = eo; x.ck_d = ck_d;
    return x;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic apply(input logic r, iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic st, fl, ordy);
    rst_n = r; bus.in_valid = iv; bus.in_data = d; bus.in_ctrl = c;
    bus.stall = st; bus.flush = fl; bus.out_ready = ordy;
  endtask

  // Inputs are applied just after a rising edge; outputs are sampled 1 time unit after the next one.
  task automatic run_vec(input vec_t x, input string tag);
    apply(x.r, x.iv, x.d, x.c, x.st, x.fl, x.ordy);
    #1;
    if (x.ck_rdy) chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(x.e_rdy));
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(x.ev));
    chk({tag, ".out_ctrl"},  64'(bus.out_ctrl),  64'(x.ec));
    chk({tag, ".occupancy"}, 64'(bus.occupancy), 64'(x.eo));
    if (x.ev || x.ck_d) chk({tag, ".out_data"}, bus.out_data, x.ed);
  endtask

  task automatic run_seq(input string tag);
    foreach (vecs[i]) run_vec(vecs[i], $sformatf("%s[%0d]", tag, i));
    vecs.delete();
  endtask

  initial begin
    logic          r, iv, st, fl, ordy, exp_rdy, mpop, mpush;
    logic [DW-1:0] d;
    logic [CW-1:0] c;

    apply(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // Reset held for two cycles with traffic on the input.
    vecs.push_back(v(0, 1, 64'h99, 16'hFFFF, 0, 0, 1, 0, 0, 0, 64'h0, 16'h0, 2'd0, 1));
    vecs.push_back(v(0, 1, 64'h99, 16'hFFFF, 0, 0, 1, 0, 0, 0, 64'h0, 16'h0, 2'd0, 1));
    // Back-to-back streaming of 1..8.
    for (int i = 1; i <= 8; i++)
      vecs.push_back(v(1, 1, 64'(i), 16'h00FF, 0, 0, 1, 1, 1, 1, 64'(i), 16'h00FF, 2'd1, 1));
    vecs.push_back(v(1, 0, 64'h0, 16'h0, 0, 0, 1, 1, 1, 0, 64'h0, 16'h0, 2'd0, 0));
    // Head held under a 3-cycle stall, popped on the first unstalled cycle.
    vecs.push_back(v(1, 1, 64'hA5, 16'h0003, 0, 0, 1, 1, 1, 1, 64'hA5, 16'h0003, 2'd1, 1));
    for (int i = 0; i < 3; i++)
      vecs.push_back(v(1, 0, 64'h0, 16'h0, 1, 0, 1, 0, 0, 1, 64'hA5, 16'h0003, 2'd1, 1));
    vecs.push_back(v(1, 0, 64'h0, 16'h0, 0, 0, 1, 1, 1, 0, 64'h0, 16'h0, 2'd0, 0));
    // Simultaneous push and pop at occupancy 1.
    vecs.push_back(v(1, 1, 64'h44, 16'h000C, 0, 0, 0, 1, 1, 1, 64'h44, 16'h000C, 2'd1, 1));
    vecs.push_back(v(1, 1, 64'h55, 16'h000D, 0, 0, 1, 1, 1, 1, 64'h55, 16'h000D, 2'd1, 1));
    vecs.push_back(v(1, 0, 64'h0, 16'h0, 0, 0, 1, 1, 1, 0, 64'h0, 16'h0, 2'd0, 0));
    // Flush with stall at occupancy 1 drops the head and the incoming 0x33.
    vecs.push_back(v(1, 1, 64'h66, 16'h0007, 0, 0, 0, 1, 1, 1, 64'h66, 16'h0007, 2'd1, 1));
    vecs.push_back(v(1, 1, 64'h33, 16'h0009, 1, 1, 0, 0, 0, 0, 64'h0, 16'h0, 2'd0, 0));
    vecs.push_back(v(1, 0, 64'h0, 16'h0, 0, 0, 1, 1, 1, 0, 64'h0, 16'h0, 2'd0, 0));
    run_seq("table");

`ifdef PIPE_SKID_EN
    // Skid fill: second push lands in the skid, in_ready drops, 0xEE is refused.
    vecs.push_back(v(1, 1, 64'h11, 16'h0001, 0, 0, 0, 1, 1, 1, 64'h11, 16'h0001, 2'd1, 1));
    vecs.push_back(v(1, 1, 64'h22, 16'h0002, 0, 0, 0, 1, 1, 1, 64'h11, 16'h0001, 2'd2, 1));
    vecs.push_back(v(1, 1, 64'hEE, 16'h0005, 0, 0, 0, 1, 0, 1, 64'h11, 16'h0001, 2'd2, 1));
    vecs.push_back(v(1, 0, 64'h0, 16'h0, 0, 0, 1, 1, 0, 1, 64'h22, 16'h0002, 2'd1, 1));
    vecs.push_back(v(1, 0, 64'h0, 16'h0, 0, 0, 1, 1, 1, 0, 64'h0, 16'h0, 2'd0, 0));
    // Flush at occupancy 2 with stall and 0x33 on the input.
    vecs.push_back(v(1, 1, 64'h11, 16'h0001, 0, 0, 0, 1, 1, 1, 64'h11, 16'h0001, 2'd1, 1));
    vecs.push_back(v(1, 1, 64'h22, 16'h0002, 0, 0, 0, 1, 1, 1, 64'h11, 16'h0001, 2'd2, 1));
    vecs.push_back(v(1, 1, 64'h33, 16'h0009, 1, 1, 0, 1, 0, 0, 64'h0, 16'h0, 2'd0, 0));
    vecs.push_back(v(1, 0, 64'h0, 16'h0, 0, 0, 1, 1, 1, 0, 64'h0, 16'h0, 2'd0, 0));
    run_seq("skid");
`else
    // Back-pressure: full stage refuses 0x88 until the head leaves.
    vecs.push_back(v(1, 1, 64'h77, 16'h0011, 0, 0, 0, 1, 1, 1, 64'h77, 16'h0011, 2'd1, 1));
    vecs.push_back(v(1, 1, 64'h88, 16'h0022, 0, 0, 0, 1, 0, 1, 64'h77, 16'h0011, 2'd1, 1));
    vecs.push_back(v(1, 0, 64'h0, 16'h0, 0, 0, 1, 1, 1, 0, 64'h0, 16'h0, 2'd0, 0));
    run_seq("bp");
`endif

    // Randomized traffic against an in-order queue model.
    for (int n = 0; n < 800; n++) begin
      r    = (n == 0) ? 1'b0 : ($urandom_range(0, 49) != 0);
      iv   = ($urandom_range(0, 3) != 0);
      d    = {$urandom, $urandom};
      c    = 16'($urandom);
      st   = ($urandom_range(0, 3) == 0);
      fl   = ($urandom_range(0, 15) == 0);
      ordy = ($urandom_range(0, 2) != 0);
      apply(r, iv, d, c, st, fl, ordy);
      #1;
`ifdef PIPE_SKID_EN
      exp_rdy = (mq.size() < 2);
`else
      exp_rdy = (mq.size() == 0) || (ordy && !st);
`endif
      if (n != 0) chk("rnd.in_ready", 64'(bus.in_ready), 64'(exp_rdy));
      if (!r || fl) begin
        mq.delete();
      end else begin
        mpop  = (mq.size() > 0) && ordy && !st;
        mpush = iv && exp_rdy;
        if (mpop) void'(mq.pop_front());
        if (mpush) mq.push_back('{d: d, c: c});
      end
      @(posedge clk);
      #1;
      chk("rnd.out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
      chk("rnd.occupancy", 64'(bus.occupancy), 64'(mq.size()));
      chk("rnd.out_ctrl", 64'(bus.out_ctrl), (mq.size() != 0) ? 64'(mq[0].c) : 64'h0);
      if (mq.size() != 0) chk("rnd.out_data", bus.out_data, mq[0].d);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
